// File: rtl/mips_multicycle_control_unit.sv
// mips_multicycle_control_unit
// Moore control FSM for a multicycle MIPS datapath. It sequences FETCH/DECODE
// and the per-class execute, memory and writeback steps, and stalls in the
// memory states until MemReady.
//
// Parameters:
//   OPCODE_W  opcode width; only the low 6 bits are decoded, narrower values are zero-extended
//   ALUOP_W   ALUOp width, minimum 3; codes are zero-extended
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset; strobes and Exception read 0 while it is low
//   Opcode       instruction opcode from IR
//   MemReady     1 = the memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA      datapath strobes and selects
//   ALUSrcB, PCSource                        2-bit mux selects
//   ALUOp        0 add, 1 sub, 2 R-type funct, 3 and, 4 or
//   State        current state encoding (debug)
//   Exception    illegal-opcode trap flag
//
// Build option:
//   ILLEGAL_TRAP_EN  if defined, an illegal opcode parks the FSM in TRAP with
//                    Exception=1 until reset. If it is not defined, an illegal
//                    opcode runs as a NOP back to FETCH.
module mips_multicycle_control_unit #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [3:0]          State,
    output logic                Exception
);

    localparam int unsigned OP_W       = 6;
    localparam int unsigned ALU_CODE_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 3'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 3'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_FUNCT = 3'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_AND   = 3'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_OR    = 3'd4;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        IEXEC  = 4'd10,
        IWB    = 4'd11,
        TRAP   = 4'd12
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [OP_W-1:0]       op;
    logic [ALU_CODE_W-1:0] alu_code;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic                  i_or_d;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  mem_to_reg;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_source;
    logic                  trap_flag;

    // Decode only the architectural 6-bit opcode field.
    assign op = OP_W'(Opcode);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_nxt     = state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_source     = PCSRC_ALU;
        alu_code      = ALU_ADD;
        trap_flag     = 1'b0;

        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // Latch IR and bump PC only in the cycle the read returns.
                if (MemReady) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = DECODE;
                end
            end

            DECODE: begin
                alu_src_b = SRCB_BOFS;
                case (op)
                    OP_RTYPE:                   state_nxt = EXEC;
                    OP_LW, OP_SW:               state_nxt = MEMADR;
                    OP_BEQ:                     state_nxt = BRANCH;
                    OP_J:                       state_nxt = JUMP;
                    OP_ANDI, OP_ORI, OP_ADDIU:  state_nxt = IEXEC;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_nxt = TRAP;
`else
                        // PC was already incremented in FETCH, so this acts as a NOP.
                        state_nxt = FETCH;
`endif
                    end
                endcase
            end

            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                // IR still holds the opcode, so lw and sw split here.
                if (op == OP_SW) begin
                    state_nxt = MEMWR;
                end else begin
                    state_nxt = MEMRD;
                end
            end

            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (MemReady) begin
                    state_nxt = MEMWB;
                end
            end

            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_nxt  = FETCH;
            end

            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (MemReady) begin
                    state_nxt = FETCH;
                end
            end

            EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_code  = ALU_FUNCT;
                state_nxt = RWB;
            end

            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_nxt = FETCH;
            end

            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                alu_code      = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_nxt     = FETCH;
            end

            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_nxt = FETCH;
            end

            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (op == OP_ANDI) begin
                    alu_code = ALU_AND;
                end else if (op == OP_ORI) begin
                    alu_code = ALU_OR;
                end else begin
                    alu_code = ALU_ADD;
                end
                state_nxt = IWB;
            end

            IWB: begin
                reg_write = 1'b1;
                state_nxt = FETCH;
            end

            TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                // Parked until reset.
                trap_flag = 1'b1;
                state_nxt = TRAP;
`else
                state_nxt = FETCH;
`endif
            end

            // Unused encodings recover to FETCH.
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Strobes are gated off combinationally while reset is held.
    assign PCWrite     = pc_write & rst_n;
    assign PCWriteCond = pc_write_cond & rst_n;
    assign MemRead     = mem_read & rst_n;
    assign MemWrite    = mem_write & rst_n;
    assign IRWrite     = ir_write & rst_n;
    assign RegWrite    = reg_write & rst_n;

    assign IorD        = i_or_d;
    assign MemtoReg    = mem_to_reg;
    assign RegDst      = reg_dst;
    assign ALUSrcA     = alu_src_a;
    assign ALUSrcB     = alu_src_b;
    assign PCSource    = pc_source;
    assign ALUOp       = ALUOP_W'(alu_code);
    assign State       = state;

`ifdef ILLEGAL_TRAP_EN
    assign Exception   = trap_flag & rst_n;
`else
    // TRAP is unreachable in this build.
    assign Exception   = 1'b0;
    logic unused_trap;
    assign unused_trap = trap_flag;
`endif

endmodule

// File: tb/tb_mips_multicycle_control_unit.sv
// tb_mips_multicycle_control_unit
// Directed vector table, hand-written reset/illegal-opcode sequences, and a
// randomized run checked against an instruction-path reference model.
module tb_mips_multicycle_control_unit;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic [2:0] aluop;
        logic [3:0] state;
        logic       exception;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       mr;
        int         st;
        logic       pcw;
        logic       pcwc;
        logic       memw;
        logic       regw;
        int         aluop;
        logic       exc;
    } vec_t;

    typedef int iq_t[$];

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] ADDI = 6'b001001;
    localparam logic [5:0] ILL  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Exception;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;

    mips_multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .State(State), .Exception(Exception)
    );

    always #5 clk = ~clk;

    outs_t got;
    always_comb begin
        got             = '0;
        got.pcwrite     = PCWrite;
        got.pcwritecond = PCWriteCond;
        got.iord        = IorD;
        got.memread     = MemRead;
        got.memwrite    = MemWrite;
        got.irwrite     = IRWrite;
        got.memtoreg    = MemtoReg;
        got.regdst      = RegDst;
        got.regwrite    = RegWrite;
        got.alusrca     = ALUSrcA;
        got.alusrcb     = ALUSrcB;
        got.pcsource    = PCSource;
        got.aluop       = ALUOp;
        got.state       = State;
        got.exception   = Exception;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
        n_chk++;
        if (g === e) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, g, e);
    endtask

    // Per-state output rows.
    outs_t row [0:15];

    task automatic build_rows();
        for (int i = 0; i < 16; i++) begin
            row[i]       = '0;
            row[i].state = 4'(i);
        end
        row[0].memread  = 1'b1; row[0].alusrcb = 2'b01;
        row[1].alusrcb  = 2'b11;
        row[2].alusrca  = 1'b1; row[2].alusrcb = 2'b10;
        row[3].memread  = 1'b1; row[3].iord = 1'b1;
        row[4].regwrite = 1'b1; row[4].memtoreg = 1'b1;
        row[5].memwrite = 1'b1; row[5].iord = 1'b1;
        row[6].alusrca  = 1'b1; row[6].aluop = 3'd2;
        row[7].regwrite = 1'b1; row[7].regdst = 1'b1;
        row[8].alusrca  = 1'b1; row[8].aluop = 3'd1;
        row[8].pcwritecond = 1'b1; row[8].pcsource = 2'b01;
        row[9].pcwrite  = 1'b1; row[9].pcsource = 2'b10;
        row[10].alusrca = 1'b1; row[10].alusrcb = 2'b10;
        row[11].regwrite = 1'b1;
        row[12].exception = 1'b1;
    endtask

    function automatic outs_t exp_out(input int st, input logic mr, input logic [5:0] op, input logic rn);
        outs_t e;
        e = row[st];
        if (st == 0) begin
            e.pcwrite = mr;
            e.irwrite = mr;
        end
        if (st == 10) e.aluop = (op == ANDI) ? 3'd3 : (op == ORI) ? 3'd4 : 3'd0;
        if (!rn) begin
            e.pcwrite = 1'b0; e.pcwritecond = 1'b0; e.irwrite = 1'b0;
            e.memread = 1'b0; e.memwrite = 1'b0; e.regwrite = 1'b0;
            e.exception = 1'b0;
        end
        return e;
    endfunction

    // States an instruction visits after DECODE.
    function automatic iq_t route(input logic [5:0] op);
        case (op)
            RT:             return '{6, 7};
            LW:             return '{2, 3, 4};
            SW:             return '{2, 5};
            BEQ:            return '{8};
            JMP:            return '{9};
            ANDI, ORI, ADDI: return '{10, 11};
`ifdef ILLEGAL_TRAP_EN
            default:        return '{12};
`else
            default:        return '{};
`endif
        endcase
    endfunction

    task automatic drive(input logic rn, input logic [5:0] op, input logic mr);
        @(negedge clk);
        rst_n    = rn;
        Opcode   = op;
        MemReady = mr;
        #1;
    endtask

    vec_t tbl[$];

    task automatic add(input logic rn, input logic [5:0] op, input logic mr, input int st,
                       input logic pcw, input logic pcwc, input logic memw, input logic regw,
                       input int alu, input logic exc);
        vec_t v;
        v = '{rn, op, mr, st, pcw, pcwc, memw, regw, alu, exc};
        tbl.push_back(v);
    endtask

    initial begin
        int         mst;
        iq_t        path;
        logic       rn, mr;
        logic [5:0] op;
        logic [5:0] ops [0:7];
        outs_t      e;

        build_rows();
        ops = '{RT, LW, SW, BEQ, JMP, ANDI, ORI, ADDI};

        // Reset: state goes to FETCH, strobes forced low even with MemReady=1.
        drive(1'b0, RT, 1'b1);
        drive(1'b0, RT, 1'b1);
        chk("reset_state", 32'(got.state), 32'd0);
        chk("reset_outputs", 32'(got), 32'(exp_out(0, 1'b1, RT, 1'b0)));

        //   rn    op    mr st pcw pcwc mw rw alu exc
        add(1'b1, RT,   1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, RT,   1, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, RT,   1, 6, 0, 0, 0, 0, 2, 0);
        add(1'b1, RT,   1, 7, 0, 0, 0, 1, 0, 0);
        add(1'b1, LW,   1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, LW,   0, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, LW,   1, 2, 0, 0, 0, 0, 0, 0);
        add(1'b1, LW,   0, 3, 0, 0, 0, 0, 0, 0);
        add(1'b1, LW,   0, 3, 0, 0, 0, 0, 0, 0);
        add(1'b1, LW,   0, 3, 0, 0, 0, 0, 0, 0);
        add(1'b1, LW,   1, 3, 0, 0, 0, 0, 0, 0);
        add(1'b1, LW,   0, 4, 0, 0, 0, 1, 0, 0);
        add(1'b1, SW,   1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, SW,   1, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, SW,   1, 2, 0, 0, 0, 0, 0, 0);
        add(1'b1, SW,   1, 5, 0, 0, 1, 0, 0, 0);
        add(1'b1, BEQ,  1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, BEQ,  1, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, BEQ,  1, 8, 0, 1, 0, 0, 1, 0);
        add(1'b1, JMP,  1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, JMP,  1, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, JMP,  1, 9, 1, 0, 0, 0, 0, 0);
        add(1'b1, ANDI, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, ANDI, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, ANDI, 1, 10, 0, 0, 0, 0, 3, 0);
        add(1'b1, ANDI, 1, 11, 0, 0, 0, 1, 0, 0);
        add(1'b1, ORI,  1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, ORI,  1, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, ORI,  1, 10, 0, 0, 0, 0, 4, 0);
        add(1'b1, ORI,  1, 11, 0, 0, 0, 1, 0, 0);
        add(1'b1, ADDI, 1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, ADDI, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, ADDI, 1, 10, 0, 0, 0, 0, 0, 0);
        add(1'b1, ADDI, 1, 11, 0, 0, 0, 1, 0, 0);
        add(1'b1, RT,   0, 0, 0, 0, 0, 0, 0, 0);
        add(1'b1, RT,   0, 0, 0, 0, 0, 0, 0, 0);
        add(1'b1, RT,   1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, RT,   1, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, RT,   0, 6, 0, 0, 0, 0, 2, 0);
        add(1'b1, RT,   0, 7, 0, 0, 0, 1, 0, 0);
        add(1'b1, SW,   1, 0, 1, 0, 0, 0, 0, 0);
        add(1'b1, SW,   1, 1, 0, 0, 0, 0, 0, 0);
        add(1'b1, SW,   0, 2, 0, 0, 0, 0, 0, 0);
        add(1'b1, SW,   0, 5, 0, 0, 1, 0, 0, 0);
        add(1'b1, SW,   0, 5, 0, 0, 1, 0, 0, 0);
        add(1'b1, SW,   1, 5, 0, 0, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].op, tbl[i].mr);
            chk($sformatf("vec%0d", i),
                {20'd0, got.state, got.pcwrite, got.pcwritecond, got.memwrite, got.regwrite,
                 got.aluop, got.exception},
                {20'd0, 4'(tbl[i].st), tbl[i].pcw, tbl[i].pcwc, tbl[i].memw, tbl[i].regw,
                 3'(tbl[i].aluop), tbl[i].exc});
            chk($sformatf("vec%0d_full", i), 32'(got),
                32'(exp_out(tbl[i].st, tbl[i].mr, tbl[i].op, tbl[i].rst_n)));
        end

        // Illegal opcode.
        drive(1'b1, ILL, 1'b1);
        chk("ill_fetch", 32'(got.state), 32'd0);
        drive(1'b1, ILL, 1'b1);
        chk("ill_decode", 32'(got.state), 32'd1);
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, ILL, 1'(k));
            chk($sformatf("trap_hold%0d", k), 32'(got), 32'(exp_out(12, 1'(k), ILL, 1'b1)));
        end
        drive(1'b0, ILL, 1'b1);
        chk("trap_rst_low", {30'd0, got.exception, got.state == 4'd12}, 32'd1);
        drive(1'b1, RT, 1'b0);
        chk("trap_released", 32'(got.state), 32'd0);
`else
        drive(1'b1, ILL, 1'b0);
        chk("ill_nop", {27'd0, got.state, got.exception}, 32'd0);
`endif

        // Reset mid-instruction while waiting in MEMRD.
        drive(1'b1, LW, 1'b1);
        drive(1'b1, LW, 1'b1);
        drive(1'b1, LW, 1'b1);
        drive(1'b1, LW, 1'b0);
        chk("memrd_wait", 32'(got), 32'(exp_out(3, 1'b0, LW, 1'b1)));
        rst_n = 1'b0;
        #1;
        chk("rst_no_async", 32'(got.state), 32'd3);
        chk("rst_force_memread", 32'(got.memread), 32'd0);
        drive(1'b0, LW, 1'b0);
        chk("rst_in_memrd", 32'(got.state), 32'd0);
        drive(1'b1, LW, 1'b1);
        chk("post_rst_fetch", 32'(got), 32'(exp_out(0, 1'b1, LW, 1'b1)));
        drive(1'b1, LW, 1'b1);
        drive(1'b1, LW, 1'b1);
        drive(1'b1, LW, 1'b1);
        drive(1'b1, LW, 1'b1);
        chk("post_rst_memwb", 32'(got.state), 32'd4);
        drive(1'b1, LW, 1'b0);
        chk("post_rst_done", 32'(got.state), 32'd0);

        // Randomized run against the instruction-path model.
        mst = 0;
        path.delete();
        for (int c = 0; c < 3000; c++) begin
            rn = ($urandom_range(0, 59) != 0);
            mr = ($urandom_range(0, 2) != 0);
            op = Opcode;
            if (mst == 0) begin
                if ($urandom_range(0, 8) == 8) op = 6'($urandom);
                else op = ops[$urandom_range(0, 7)];
            end
            drive(rn, op, mr);
            e = exp_out(mst, mr, op, rn);
            chk($sformatf("rand%0d", c), 32'(got), 32'(e));

            if (!rn) begin
                mst = 0;
                path.delete();
            end else if ((mst == 0 || mst == 3 || mst == 5) && !mr) begin
                mst = mst;
            end else if (mst == 0) begin
                mst = 1;
            end else if (mst == 1) begin
                path = route(op);
                mst  = (path.size() > 0) ? path.pop_front() : 0;
            end else if (mst == 12) begin
                mst = 12;
            end else begin
                mst = (path.size() > 0) ? path.pop_front() : 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
